// File: rtl/reaction_timer.sv
// reaction_timer: times the driver's reaction from lights-out to button press in tick units
module reaction_timer #(
    parameter int D_WIDTH = 8,
    parameter int T_WIDTH = 16,
    parameter int MAX_MS  = 9999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [D_WIDTH-1:0] lights,
    input  logic               btn,
    output logic [T_WIDTH-1:0] time_ms,
    output logic               valid,
    output logic               foul,
    output logic               timeout,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FOUL, TIMEOUT} state_t;

    state_t             state_q, state_d;
    logic [T_WIDTH-1:0] cnt_q, cnt_d, time_q, time_d;
    logic               full_q, full_d, valid_q, valid_d, foul_q, foul_d;
    logic               to_q, to_d, busy_q, busy_d;
    logic               btn_s1_q, btn_s2_q, btn_s3_q;
    logic               btn_s1_d, btn_s2_d, btn_s3_d;
    logic               press;
    logic               lit, all_lit;

    assign lit     = lights != '0;
    assign all_lit = lights == '1;
    assign press   = btn_s2_q & ~btn_s3_q;

    // Two-flop synchroniser plus a delay stage for rising-edge detection
    always_comb begin
        btn_s1_d = btn;
        btn_s2_d = btn_s1_q;
        btn_s3_d = btn_s2_q;
    end

    // Next-state and registered-output logic; results are held until a new sequence lights up
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        time_d  = time_q;
        valid_d = valid_q;
        foul_d  = foul_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (lit) begin
                    state_d = ARMED;
                    full_d  = 1'b0;
                end
            end
            ARMED: begin
                if (press) begin
                    state_d = FOUL;
                    foul_d  = 1'b1;
                end else if (all_lit) begin
                    full_d = 1'b1;
                end else if (!lit) begin
                    state_d = full_q ? TIMING : IDLE;
                    cnt_d   = '0;
                end
            end
            TIMING: begin
                if (press) begin
                    state_d = DONE;
                    time_d  = cnt_q;
                    valid_d = 1'b1;
                end else if (lit) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                    full_d  = 1'b0;
                end else if (tick) begin
                    if (cnt_q == T_WIDTH'(MAX_MS - 1)) begin
                        state_d = TIMEOUT;
                        cnt_d   = T_WIDTH'(MAX_MS);
                        time_d  = T_WIDTH'(MAX_MS);
                        to_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (lit) begin
                    state_d = ARMED;
                    time_d  = '0;
                    valid_d = 1'b0;
                    foul_d  = 1'b0;
                    to_d    = 1'b0;
                    full_d  = 1'b0;
                end
            end
        endcase
        busy_d = (state_d == ARMED) || (state_d == TIMING);
    end

    // State, counter, synchroniser and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            time_q   <= '0;
            valid_q  <= 1'b0;
            foul_q   <= 1'b0;
            to_q     <= 1'b0;
            busy_q   <= 1'b0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            btn_s3_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            time_q   <= time_d;
            valid_q  <= valid_d;
            foul_q   <= foul_d;
            to_q     <= to_d;
            busy_q   <= busy_d;
            btn_s1_q <= btn_s1_d;
            btn_s2_q <= btn_s2_d;
            btn_s3_q <= btn_s3_d;
        end
    end

    assign time_ms = time_q;
    assign valid   = valid_q;
    assign foul    = foul_q;
    assign timeout = to_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: vector table plus scoreboarded hand sequences for reaction_timer
module tb_reaction_timer;
    logic        clk, rst, tick, btn;
    logic [7:0]  lights;
    logic [15:0] tm1, tm2;
    logic        v1, f1, to1, bz1, v2, f2, to2, bz2;

    reaction_timer dut1 (
        .clk(clk), .rst(rst), .tick(tick), .lights(lights), .btn(btn),
        .time_ms(tm1), .valid(v1), .foul(f1), .timeout(to1), .busy(bz1)
    );

    reaction_timer #(.MAX_MS(20)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .lights(lights), .btn(btn),
        .time_ms(tm2), .valid(v2), .foul(f2), .timeout(to2), .busy(bz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  l;
        logic        b;
        logic        t;
        logic        bz;
        logic        v;
        logic        f;
        logic        to;
        logic [15:0] tm;
    } vec_t;

    typedef struct {
        string       name;
        logic        sel;
        logic        bz;
        logic        v;
        logic        f;
        logic        to;
        logic [15:0] tm;
    } exp_t;

    exp_t q[$];
    vec_t tbl[18];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string n, input logic sel, input logic bz, input logic v,
                        input logic f, input logic to, input logic [15:0] tm);
        exp_t e;
        e.name = n; e.sel = sel; e.bz = bz; e.v = v; e.f = f; e.to = to; e.tm = tm;
        q.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        logic bz, v, f, to;
        logic [15:0] tm;
        e  = q.pop_front();
        bz = e.sel ? bz2 : bz1;
        v  = e.sel ? v2  : v1;
        f  = e.sel ? f2  : f1;
        to = e.sel ? to2 : to1;
        tm = e.sel ? tm2 : tm1;
        total++;
        if ({bz, v, f, to, tm} !== {e.bz, e.v, e.f, e.to, e.tm}) begin
            bad++;
            $display("FAIL %s dut%0d: got busy=%b valid=%b foul=%b timeout=%b time=%0d, want busy=%b valid=%b foul=%b timeout=%b time=%0d",
                     e.name, e.sel + 1, bz, v, f, to, tm, e.bz, e.v, e.f, e.to, e.tm);
        end
    endtask

    task automatic expect_now(input string n, input logic sel, input logic bz, input logic v,
                              input logic f, input logic to, input logic [15:0] tm);
        push(n, sel, bz, v, f, to, tm);
        chk();
    endtask

    task automatic cyc(input logic [7:0] l, input logic b, input logic t);
        lights = l;
        btn    = b;
        tick   = t;
        @(negedge clk);
    endtask

    task automatic ramp();
        for (int i = 1; i <= 8; i++) cyc(8'((16'd1 << i) - 1), btn, 1'b0);
        cyc(8'h00, btn, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{8'h00, 0, 0, 0, 0, 0, 0, 16'd0};
        tbl[1]  = '{8'h03, 0, 0, 1, 0, 0, 0, 16'd0};
        tbl[2]  = '{8'h03, 0, 0, 1, 0, 0, 0, 16'd0};
        tbl[3]  = '{8'h00, 0, 0, 0, 0, 0, 0, 16'd0};
        tbl[4]  = '{8'h00, 1, 0, 0, 0, 0, 0, 16'd0};
        tbl[5]  = '{8'h00, 1, 0, 0, 0, 0, 0, 16'd0};
        tbl[6]  = '{8'h00, 1, 0, 0, 0, 0, 0, 16'd0};
        tbl[7]  = '{8'h00, 0, 0, 0, 0, 0, 0, 16'd0};
        tbl[8]  = '{8'h01, 0, 0, 1, 0, 0, 0, 16'd0};
        tbl[9]  = '{8'hFF, 0, 0, 1, 0, 0, 0, 16'd0};
        tbl[10] = '{8'h00, 0, 1, 1, 0, 0, 0, 16'd0};
        tbl[11] = '{8'h00, 0, 1, 1, 0, 0, 0, 16'd0};
        tbl[12] = '{8'h00, 0, 1, 1, 0, 0, 0, 16'd0};
        tbl[13] = '{8'h00, 1, 0, 1, 0, 0, 0, 16'd0};
        tbl[14] = '{8'h00, 1, 1, 1, 0, 0, 0, 16'd0};
        tbl[15] = '{8'h00, 1, 1, 0, 1, 0, 0, 16'd3};
        tbl[16] = '{8'h00, 0, 0, 0, 1, 0, 0, 16'd3};
        tbl[17] = '{8'h00, 0, 1, 0, 1, 0, 0, 16'd3};

        rst = 1'b1; lights = 8'h00; btn = 1'b0; tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_now("reset_state", 0, 0, 0, 0, 0, 16'd0);
        expect_now("reset_state", 1, 0, 0, 0, 0, 16'd0);
        rst = 1'b0;

        // aborted sequence, ignored presses, short timed run with press+tick collision
        for (int i = 0; i < 18; i++) begin
            push("table", 0, tbl[i].bz, tbl[i].v, tbl[i].f, tbl[i].to, tbl[i].tm);
            cyc(tbl[i].l, tbl[i].b, tbl[i].t);
            chk();
        end

        // reset asserted mid-timing wipes everything immediately
        ramp();
        repeat (37) cyc(8'h00, 1'b0, 1'b1);
        expect_now("timing_37", 0, 1, 0, 0, 0, 16'd0);
        #2 rst = 1'b1;
        #1 expect_now("rst_async", 0, 0, 0, 0, 0, 16'd0);
        expect_now("rst_async", 1, 0, 0, 0, 0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cyc(8'h00, 1'b0, 1'b0);
        expect_now("rst_idle", 0, 0, 0, 0, 0, 16'd0);

        // 250 tick reaction; MAX_MS=20 instance times out along the way
        ramp();
        for (int i = 1; i <= 250; i++) begin
            cyc(8'h00, 1'b0, 1'b1);
            if (i == 19) expect_now("to_edge19", 1, 1, 0, 0, 0, 16'd0);
            if (i == 20) expect_now("to_edge20", 1, 0, 0, 0, 1, 16'd20);
        end
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        expect_now("sync_wait", 0, 1, 0, 0, 0, 16'd0);
        cyc(8'h00, 1'b1, 1'b0);
        expect_now("react_250", 0, 0, 1, 0, 0, 16'd250);
        repeat (4) cyc(8'h00, 1'b1, 1'b0);

        // held button across a new sequence must not foul; press coincident with tick at 99
        ramp();
        expect_now("held_nofoul", 0, 1, 0, 0, 0, 16'd0);
        repeat (3) cyc(8'h00, 1'b0, 1'b0);
        repeat (99) cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b1);
        expect_now("press_tick_99", 0, 0, 1, 0, 0, 16'd99);
        expect_now("to_press_ign", 1, 0, 0, 0, 1, 16'd20);
        repeat (500) cyc(8'h00, 1'b1, 1'b1);
        expect_now("held_500", 0, 0, 1, 0, 0, 16'd99);

        // jump start, further presses ignored, next sequence clears
        repeat (3) cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h01, 1'b0, 1'b0);
        expect_now("rearm_clear", 0, 1, 0, 0, 0, 16'd0);
        expect_now("rearm_clear", 1, 1, 0, 0, 0, 16'd0);
        cyc(8'h0F, 1'b1, 1'b0);
        cyc(8'h0F, 1'b1, 1'b0);
        cyc(8'h0F, 1'b1, 1'b0);
        expect_now("foul", 0, 0, 0, 1, 0, 16'd0);
        repeat (3) cyc(8'h00, 1'b0, 1'b0);
        repeat (3) cyc(8'h00, 1'b1, 1'b1);
        expect_now("foul_hold", 0, 0, 0, 1, 0, 16'd0);
        cyc(8'h01, 1'b1, 1'b0);
        expect_now("foul_clear", 0, 1, 0, 0, 0, 16'd0);

        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got %0d leftover entries, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
